eth_rx_demux: RTL
=================

// Module: eth_rx_demux
// PURPOSE
//  Receive-side counterpart of the TX port mux: splits one incoming Ethernet AXI stream
//  into a host ("xmit") stream and a loopback ("loop") stream. Routing is decided per
//  packet, never mid-packet. Sits between the MAC RX output and the host/loopback paths.
//  Each output has a registered skid stage; per-destination packet and drop counters.
// PARAMETERS
//  DW   512  tdata width, bits
//  CW   32   width of each packet counter
// PORTS
//  clk               in   1    sole clock
//  reset             in   1    synchronous, active-high
//  port_select       in   1    0 = route to axis_xmit, 1 = route to axis_loop
//  xmit_enable       in   1    0 = packets routed to xmit are consumed and dropped
//  loop_enable       in   1    0 = packets routed to loop are consumed and dropped
//  axis_in_tdata     in   DW   incoming stream from MAC
//  axis_in_tlast     in   1
//  axis_in_tvalid    in   1
//  axis_in_tready    out  1
//  axis_xmit_tdata   out  DW   host-bound stream
//  axis_xmit_tlast   out  1
//  axis_xmit_tvalid  out  1
//  axis_xmit_tready  in   1
//  axis_loop_tdata   out  DW   loopback stream
//  axis_loop_tlast   out  1
//  axis_loop_tvalid  out  1
//  axis_loop_tready  in   1
//  xmit_pkts         out  CW   packets delivered to xmit
//  loop_pkts         out  CW   packets delivered to loop
//  drop_pkts         out  CW   packets discarded (destination disabled)
// BEHAVIOUR
//  - Handshake = beat accepted when tvalid && tready in the same clk edge (all ports).
//  - FSM: S_SOP (next beat is first of a packet) / S_BODY. Reset -> S_SOP.
//    S_SOP: on accepted beat, latch route = port_select, drop = !enable[route] (both
//    sampled that cycle); if tlast also set, stay S_SOP, else -> S_BODY.
//    S_BODY: route/drop held; accepted beat with tlast -> S_SOP.
//  - Beat steering uses route/drop live in S_SOP, latched in S_BODY. port_select and
//    enables changing mid-packet have no effect until the next first beat.
//  - Not dropping: beat goes to selected skid stage; axis_in_tready = that stage's s_ready.
//    Non-selected stage receives no beats. Dropping: axis_in_tready = 1, beat discarded.
//  - Skid stage: 2-entry (main + skid) register; output latency 1 clk; sustains 1 beat/clk
//    under continuous tready; s_ready = !skid_full (registered). tdata/tlast unchanged.
//  - One output backpressured never stalls packets routed to the other once the current
//    packet has fully entered its stage (no head-of-line block beyond that packet).
//  - Counters increment on the tlast beat: xmit/loop when that beat enters the stage,
//    drop when that beat is discarded. Wrap 2^CW-1 -> 0. One increment per clk max.
//  - Reset values: axis_in_tready=0, axis_*_tvalid=0, tdata/tlast=0, counters=0,
//    FSM=S_SOP, both skid stages empty. axis_in_tready rises the clk after reset falls.
//  - Reset mid-packet: stage contents flushed (partial packet lost, not counted); the
//    next accepted input beat is treated as a first beat. Upstream MAC is reset together.
//  - Single-beat packets (tlast on first beat) fully supported, back-to-back.
// STRUCTURE
//  - Shared package eth_pkg: DW default, route encodings (ROUTE_XMIT=0, ROUTE_LOOP=1),
//    FSM state typedef (S_SOP, S_BODY).
//  - Sub-module axis_skid_slice #(DW) (s_/m_ AXIS, clk, reset), instantiated twice.
//  - Top holds FSM, route/drop latches, steering, counters.
// TESTING
//  1. port_select=0, 4-beat pkt, xmit_tready=1 -> 4 beats on xmit, first 1 clk after
//     input, loop_tvalid never 1, xmit_pkts=1.
//  2. Start 8-beat pkt with port_select=0, flip to 1 at beat 3 -> all 8 beats on xmit;
//     next pkt goes to loop; xmit_pkts=1, loop_pkts=1.
//  3. loop_enable=0, port_select=1, 3 pkts of 5 beats -> axis_in_tready=1 throughout,
//     no output beats, drop_pkts=3.
//  4. xmit_tready toggled randomly 50%, 100 pkts of 1..16 beats -> output data/tlast
//     order identical to input, no beat lost or duplicated; tready=1 gives 1 beat/clk.
//  5. Preload xmit_pkts to 2^CW-1 (force) and send 1 pkt -> xmit_pkts=0.
//  6. Assert reset at beat 4 of 10-beat pkt -> tvalid=0 next clk, counters 0; next pkt
//     after reset routed per port_select and counted normally.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet RX demux: widths, route encodings, FSM states.
package eth_pkg;

    localparam int DW_DEF = 512;
    localparam int CW_DEF = 32;

    localparam logic ROUTE_XMIT = 1'b0;
    localparam logic ROUTE_LOOP = 1'b1;

    typedef enum logic {
        S_SOP  = 1'b0,
        S_BODY = 1'b1
    } rx_state_e;

endpackage

// File: rtl/axis_skid_slice.sv
// Two-entry AXI-stream register slice: one clock of latency, full throughput,
// upstream ready taken from a flop so no combinational path crosses the slice.
module axis_skid_slice #(
    parameter int DW = 512
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] s_tdata_i,
    input  logic          s_tlast_i,
    input  logic          s_tvalid_i,
    output logic          s_tready_o,
    output logic [DW-1:0] m_tdata_o,
    output logic          m_tlast_o,
    output logic          m_tvalid_o,
    input  logic          m_tready_i
);

    logic [DW-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic          main_last_q, main_last_d, skid_last_q, skid_last_d;
    logic          main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic          ready_q;
    logic          s_fire, m_fire;

    assign s_fire = s_tvalid_i && ready_q;
    assign m_fire = main_valid_q && m_tready_i;

    always_comb begin
        main_data_d  = main_data_q;
        main_last_d  = main_last_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            // Upstream is held off while the skid entry is occupied.
            if (m_fire) begin
                main_data_d  = skid_data_q;
                main_last_d  = skid_last_q;
                skid_valid_d = 1'b0;
            end
        end else if (!main_valid_q || m_fire) begin
            main_valid_d = s_fire;
            if (s_fire) begin
                main_data_d = s_tdata_i;
                main_last_d = s_tlast_i;
            end
        end else if (s_fire) begin
            skid_data_d  = s_tdata_i;
            skid_last_d  = s_tlast_i;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_data_q  <= '0;
            main_last_q  <= 1'b0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_last_q  <= main_last_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
        end
    end

    assign s_tready_o = ready_q;
    assign m_tdata_o  = main_data_q;
    assign m_tlast_o  = main_last_q;
    assign m_tvalid_o = main_valid_q;

endmodule

// File: rtl/eth_rx_demux.sv
// Splits the MAC RX stream into host (xmit) and loopback streams, choosing the
// destination once per packet; disabled destinations have their packets discarded.
module eth_rx_demux
    import eth_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          port_select,
    input  logic          xmit_enable,
    input  logic          loop_enable,
    input  logic [DW-1:0] axis_in_tdata,
    input  logic          axis_in_tlast,
    input  logic          axis_in_tvalid,
    output logic          axis_in_tready,
    output logic [DW-1:0] axis_xmit_tdata,
    output logic          axis_xmit_tlast,
    output logic          axis_xmit_tvalid,
    input  logic          axis_xmit_tready,
    output logic [DW-1:0] axis_loop_tdata,
    output logic          axis_loop_tlast,
    output logic          axis_loop_tvalid,
    input  logic          axis_loop_tready,
    output logic [CW-1:0] xmit_pkts,
    output logic [CW-1:0] loop_pkts,
    output logic [CW-1:0] drop_pkts
);

    rx_state_e     state_q, state_d;
    logic          route_q, route_d, drop_q, drop_d;
    logic          run_q;
    logic [CW-1:0] xmit_pkts_q, xmit_pkts_d, loop_pkts_q, loop_pkts_d;
    logic [CW-1:0] drop_pkts_q, drop_pkts_d;
    logic          route_cur, drop_cur, in_fire;
    logic          xmit_s_valid, xmit_s_ready, loop_s_valid, loop_s_ready;

    // First beat decides from live inputs; later beats follow the latched decision.
    always_comb begin
        route_cur = route_q;
        drop_cur  = drop_q;
        if (state_q == S_SOP) begin
            route_cur = port_select;
            drop_cur  = (port_select == ROUTE_LOOP) ? !loop_enable : !xmit_enable;
        end
    end

    assign axis_in_tready = drop_cur ? run_q
                          : ((route_cur == ROUTE_LOOP) ? loop_s_ready : xmit_s_ready);
    assign in_fire        = axis_in_tvalid && axis_in_tready;
    assign xmit_s_valid   = axis_in_tvalid && !drop_cur && (route_cur == ROUTE_XMIT);
    assign loop_s_valid   = axis_in_tvalid && !drop_cur && (route_cur == ROUTE_LOOP);

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        drop_d  = drop_q;
        case (state_q)
            S_SOP: begin
                if (in_fire) begin
                    route_d = route_cur;
                    drop_d  = drop_cur;
                    if (!axis_in_tlast) state_d = S_BODY;
                end
            end
            S_BODY: begin
                if (in_fire && axis_in_tlast) state_d = S_SOP;
            end
            default: state_d = S_SOP;
        endcase
    end

    always_comb begin
        xmit_pkts_d = xmit_pkts_q;
        loop_pkts_d = loop_pkts_q;
        drop_pkts_d = drop_pkts_q;
        if (in_fire && axis_in_tlast) begin
            if (drop_cur)                      drop_pkts_d = drop_pkts_q + 1'b1;
            else if (route_cur == ROUTE_LOOP)  loop_pkts_d = loop_pkts_q + 1'b1;
            else                               xmit_pkts_d = xmit_pkts_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_SOP;
            route_q     <= ROUTE_XMIT;
            drop_q      <= 1'b0;
            run_q       <= 1'b0;
            xmit_pkts_q <= '0;
            loop_pkts_q <= '0;
            drop_pkts_q <= '0;
        end else begin
            state_q     <= state_d;
            route_q     <= route_d;
            drop_q      <= drop_d;
            run_q       <= 1'b1;
            xmit_pkts_q <= xmit_pkts_d;
            loop_pkts_q <= loop_pkts_d;
            drop_pkts_q <= drop_pkts_d;
        end
    end

    assign xmit_pkts = xmit_pkts_q;
    assign loop_pkts = loop_pkts_q;
    assign drop_pkts = drop_pkts_q;

    axis_skid_slice #(.DW(DW)) u_xmit_slice (
        .clk        (clk),
        .reset      (reset),
        .s_tdata_i  (axis_in_tdata),
        .s_tlast_i  (axis_in_tlast),
        .s_tvalid_i (xmit_s_valid),
        .s_tready_o (xmit_s_ready),
        .m_tdata_o  (axis_xmit_tdata),
        .m_tlast_o  (axis_xmit_tlast),
        .m_tvalid_o (axis_xmit_tvalid),
        .m_tready_i (axis_xmit_tready)
    );

    axis_skid_slice #(.DW(DW)) u_loop_slice (
        .clk        (clk),
        .reset      (reset),
        .s_tdata_i  (axis_in_tdata),
        .s_tlast_i  (axis_in_tlast),
        .s_tvalid_i (loop_s_valid),
        .s_tready_o (loop_s_ready),
        .m_tdata_o  (axis_loop_tdata),
        .m_tlast_o  (axis_loop_tlast),
        .m_tvalid_o (axis_loop_tvalid),
        .m_tready_i (axis_loop_tready)
    );

endmodule
